// File: rtl/controle_pkg.sv
// Shared definitions for the controle sequencer: state codes, mux select
// codes, ULA operation helper and the packed control word.
package controle_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LDX  = 3'd1;
  localparam state_t ST_MAB  = 3'd2;
  localparam state_t ST_ADB  = 3'd3;
  localparam state_t ST_MUX2 = 3'd4;
  localparam state_t ST_ADC  = 3'd5;
  localparam state_t ST_FIM  = 3'd6;

  // M0 selects (operand constants)
  localparam logic [1:0] SEL_ZERO = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  // M1 selects (first ULA input)
  localparam logic [1:0] SEL1_OUTM0 = 2'b00;
  localparam logic [1:0] SEL1_REGX  = 2'b01;
  localparam logic [1:0] SEL1_REGS  = 2'b10;
  localparam logic [1:0] SEL1_REGH  = 2'b11;

  // M2 selects (second ULA input)
  localparam logic [1:0] SEL2_REGX  = 2'b00;
  localparam logic [1:0] SEL2_OUTM0 = 2'b01;
  localparam logic [1:0] SEL2_REGS  = 2'b10;
  localparam logic [1:0] SEL2_REGH  = 2'b11;

  // Abstract ULA operation kinds; the physical h code depends on H_MUL
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef struct packed {
    logic       lx;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] m2;
    logic       h;
    logic       ls;
    logic       lh;
    logic       done;
    logic       ocupado;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = ctrl_t'(12'h000);

  // Map an abstract operation kind onto the h encoding of the operativo
  function automatic logic ula_code(input logic is_mul, input logic h_mul);
    return is_mul ? h_mul : ~h_mul;
  endfunction

endpackage

// File: rtl/controle_dec.sv
// Control word decoder: turns a state (and the captured mode) into the
// full set of datapath strobes and selects. Purely combinational.
module controle_dec
  import controle_pkg::*;
#(
  parameter logic H_MUL = 1'b1
) (
  input  state_t state,
  input  logic   modo_r,
  output ctrl_t  cw
);

  // Decode the control word for the given state; unused selects stay 00
  always_comb begin
    cw = CTRL_IDLE;
    case (state)
      ST_IDLE: cw = CTRL_IDLE;
      ST_LDX: begin
        cw.lx      = 1'b1;
        cw.ocupado = 1'b1;
      end
      ST_MAB: begin
        cw.m0      = SEL_A;
        cw.m1      = SEL1_OUTM0;
        cw.m2      = SEL2_REGX;
        cw.h       = ula_code(OP_MUL, H_MUL);
        cw.lh      = 1'b1;
        cw.ocupado = 1'b1;
      end
      ST_ADB: begin
        cw.m0      = SEL_B;
        cw.m1      = SEL1_OUTM0;
        cw.m2      = SEL2_REGH;
        cw.h       = ula_code(OP_ADD, H_MUL);
        cw.lh      = 1'b1;
        cw.ocupado = 1'b1;
      end
      ST_MUX2: begin
        // Linear mode starts the chain with B*X, quadratic continues with RegH*X
        if (modo_r) begin
          cw.m0 = SEL_B;
          cw.m1 = SEL1_OUTM0;
        end else begin
          cw.m0 = SEL_ZERO;
          cw.m1 = SEL1_REGH;
        end
        cw.m2      = SEL2_REGX;
        cw.h       = ula_code(OP_MUL, H_MUL);
        cw.lh      = 1'b1;
        cw.ocupado = 1'b1;
      end
      ST_ADC: begin
        cw.m0      = SEL_C;
        cw.m1      = SEL1_OUTM0;
        cw.m2      = SEL2_REGH;
        cw.h       = ula_code(OP_ADD, H_MUL);
        cw.ls      = 1'b1;
        cw.ocupado = 1'b1;
      end
      ST_FIM: begin
        cw.done    = 1'b1;
        cw.ocupado = 1'b1;
      end
      default: cw = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/controle.sv
// Sequencer for the operativo datapath evaluating A*X^2+B*X+C (modo=0) or
// B*X+C (modo=1). Moore machine; the control word is registered from the
// decode of the next state so outputs never see inicio/modo combinationally.
module controle
  import controle_pkg::*;
#(
  parameter logic H_MUL = 1'b1
) (
  input  logic       ck,
  input  logic       rst,
  input  logic       inicio,
  input  logic       modo,
  output logic       lx,
  output logic [1:0] m0,
  output logic [1:0] m1,
  output logic [1:0] m2,
  output logic       h,
  output logic       ls,
  output logic       lh,
  output logic       done,
  output logic       ocupado
);

  state_t state_r;
  state_t state_nxt;
  logic   modo_r;
  logic   modo_nxt;
  ctrl_t  ctrl_nxt;
  ctrl_t  ctrl_r;

  // Next-state logic; inicio and modo are only looked at in IDLE
  always_comb begin
    state_nxt = state_r;
    modo_nxt  = modo_r;
    case (state_r)
      ST_IDLE: begin
        if (inicio) begin
          state_nxt = ST_LDX;
          modo_nxt  = modo;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_LDX: begin
        if (modo_r) begin
          state_nxt = ST_MUX2;
        end else begin
          state_nxt = ST_MAB;
        end
      end
      ST_MAB:  state_nxt = ST_ADB;
      ST_ADB:  state_nxt = ST_MUX2;
      ST_MUX2: state_nxt = ST_ADC;
      ST_ADC:  state_nxt = ST_FIM;
      ST_FIM:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  controle_dec #(.H_MUL(H_MUL)) u_dec (
    .state  (state_nxt),
    .modo_r (modo_nxt),
    .cw     (ctrl_nxt)
  );

  // State, captured mode and registered control word
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      modo_r  <= 1'b0;
      ctrl_r  <= CTRL_IDLE;
    end else begin
      state_r <= state_nxt;
      modo_r  <= modo_nxt;
      ctrl_r  <= ctrl_nxt;
    end
  end

  assign lx      = ctrl_r.lx;
  assign m0      = ctrl_r.m0;
  assign m1      = ctrl_r.m1;
  assign m2      = ctrl_r.m2;
  assign h       = ctrl_r.h;
  assign ls      = ctrl_r.ls;
  assign lh      = ctrl_r.lh;
  assign done    = ctrl_r.done;
  assign ocupado = ctrl_r.ocupado;

endmodule
